// File: rtl/bitmask_scan_sched.sv
// bitmask_scan_sched: emits one MSB-referenced bit index per beat for each set bit of an accepted mask
module bitmask_scan_sched #(
    parameter int WIDTH = 5,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_bitmask,
    input  logic             in_val,
    output logic             in_rdy,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_zero,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SCAN, ZERO} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] rem, rem_nxt, hi;
    logic [IDX_W-1:0] idx;
    always_comb begin
        hi = '0;
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (rem[i]) begin
                hi = '0;
                hi[i] = 1'b1;
                idx = IDX_W'(WIDTH - 1 - i);
            end
    end
    assign out_val  = state != IDLE;
    assign out_zero = state == ZERO;
    assign out_idx  = state == SCAN ? idx : '0;
    assign out_last = out_zero || (state == SCAN && (rem & (rem - WIDTH'(1))) == '0);
    assign in_rdy   = !reset && (state == IDLE || (out_val && out_last && out_rdy));
    assign busy     = out_val;
    // a load in the same cycle as the final beat overrides the return to IDLE
    always_comb begin
        state_nxt = state;
        rem_nxt = rem;
        if (out_val && out_rdy) begin
            rem_nxt = rem & ~hi;
            if (out_last) state_nxt = IDLE;
        end
        if (in_val && in_rdy) begin
            rem_nxt = in_bitmask;
            state_nxt = |in_bitmask ? SCAN : ZERO;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rem <= '0;
        end else begin
            state <= state_nxt;
            rem <= rem_nxt;
        end
    end
endmodule

// File: tb/tb_bitmask_scan_sched.sv
// tb_bitmask_scan_sched: directed and randomized-handshake checks of the bitmask scan scheduler
module tb_bitmask_scan_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] in_bitmask = '0;
    logic in_val = 1'b0;
    logic in_rdy;
    logic [2:0] out_idx;
    logic out_last, out_zero, out_val;
    logic out_rdy = 1'b1;
    logic busy;
    int checks = 0;
    int errors = 0;

    bitmask_scan_sched #(.WIDTH(5), .IDX_W(3)) dut (
        .clk(clk), .reset(reset), .in_bitmask(in_bitmask), .in_val(in_val), .in_rdy(in_rdy),
        .out_idx(out_idx), .out_last(out_last), .out_zero(out_zero), .out_val(out_val),
        .out_rdy(out_rdy), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [2:0] idx, input logic last, input logic zero);
        chk({tag, "_val"}, out_val, 1'b1);
        chk({tag, "_idx"}, out_idx, idx);
        chk({tag, "_last"}, out_last, last);
        chk({tag, "_zero"}, out_zero, zero);
    endtask

    logic [4:0] mask;
    int b;
    logic done;

    initial begin
        #2;
        chk("rst_val", out_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", in_rdy, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_last", out_last, 0);
        chk("rst_zero", out_zero, 0);
        @(negedge clk);
        reset = 1'b0;

        // 10110 -> idx 0, 2, 3
        in_bitmask = 5'b10110; in_val = 1'b1; out_rdy = 1'b1; #1;
        chk("t1_rdy_idle", in_rdy, 1);
        cyc(); in_val = 1'b0; #1;
        beat("t1_b0", 3'd0, 0, 0);
        chk("t1_busy", busy, 1);
        chk("t1_rdy_mid", in_rdy, 0);
        cyc(); #1; beat("t1_b1", 3'd2, 0, 0);
        cyc(); #1; beat("t1_b2", 3'd3, 1, 0);
        chk("t1_rdy_last", in_rdy, 1);
        cyc(); #1;
        chk("t1_idle_val", out_val, 0);
        chk("t1_idle_busy", busy, 0);

        // zero mask
        in_bitmask = 5'b00000; in_val = 1'b1;
        cyc(); in_val = 1'b0; #1;
        beat("t2_zero", 3'd0, 1, 1);
        chk("t2_rdy", in_rdy, 1);
        cyc(); #1;
        chk("t2_idle", out_val, 0);

        // back-to-back, no bubble
        in_bitmask = 5'b00001; in_val = 1'b1;
        cyc(); in_bitmask = 5'b11000; #1;
        beat("t3_b0", 3'd4, 1, 0);
        chk("t3_rdy", in_rdy, 1);
        cyc(); in_val = 1'b0; #1;
        beat("t3_b1", 3'd0, 0, 0);
        cyc(); #1; beat("t3_b2", 3'd1, 1, 0);
        cyc(); #1;
        chk("t3_idle", out_val, 0);

        // backpressure
        in_bitmask = 5'b11111; in_val = 1'b1;
        cyc(); in_val = 1'b0; out_rdy = 1'b0; in_bitmask = 5'b00010;
        for (int k = 0; k < 4; k++) begin
            #1;
            beat("t4_hold", 3'd0, 0, 0);
            chk("t4_hold_rdy", in_rdy, 0);
            cyc();
        end
        out_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            beat("t4_run", 3'(k), k == 4, 0);
            cyc();
        end
        #1;
        chk("t4_idle", out_val, 0);

        // async reset mid-scan
        in_bitmask = 5'b11111; in_val = 1'b1;
        cyc(); in_val = 1'b0; #1;
        beat("t5_b0", 3'd0, 0, 0);
        cyc(); #1; beat("t5_b1", 3'd1, 0, 0);
        cyc(); #1;
        reset = 1'b1; #1;
        chk("t5_rst_val", out_val, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rdy", in_rdy, 0);
        @(negedge clk);
        reset = 1'b0;
        in_bitmask = 5'b00100; in_val = 1'b1;
        cyc(); in_val = 1'b0; #1;
        beat("t5_after", 3'd2, 1, 0);
        cyc(); #1;
        chk("t5_idle", out_val, 0);

        // random masks with random downstream stalls
        for (int m = 0; m < 200; m++) begin
            mask = 5'($urandom_range(0, 31));
            in_bitmask = mask; in_val = 1'b1;
            cyc(); in_val = 1'b0; in_bitmask = 5'($urandom_range(0, 31));
            b = 4; done = 1'b0;
            for (int c = 0; c < 60 && !done; c++) begin
                out_rdy = 1'($urandom_range(0, 1)); #1;
                if (out_val && out_rdy) begin
                    if (mask == 5'd0) begin
                        beat("rnd_zero", 3'd0, 1, 1);
                        done = 1'b1;
                    end else begin
                        while (b > 0 && !mask[b]) b--;
                        done = (mask & ((5'd1 << b) - 5'd1)) == 5'd0;
                        beat("rnd_bit", 3'(4 - b), done, 0);
                        b--;
                    end
                end
                cyc();
            end
            chk("rnd_done", done, 1);
            chk("rnd_idle", out_val, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
